// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU slice: datapath widths, opcode encodings,
// the fetch-stage state enum and a small saturating-increment helper.
package cpu_pkg;

    // Instruction format: [15:13] opcode, [12:0] operand (address/immediate).
    localparam int ADDR_W    = 13;
    localparam int INSTR_W   = 16;
    localparam int OPCODE_W  = 3;
    localparam int RETIRED_W = 16;

    localparam logic [OPCODE_W-1:0] OP_LDA = 3'd0;
    localparam logic [OPCODE_W-1:0] OP_STA = 3'd1;
    localparam logic [OPCODE_W-1:0] OP_ADD = 3'd2;
    localparam logic [OPCODE_W-1:0] OP_SUB = 3'd3;
    localparam logic [OPCODE_W-1:0] OP_JMP = 3'd4;
    localparam logic [OPCODE_W-1:0] OP_JEZ = 3'd5;
    localparam logic [OPCODE_W-1:0] OP_LDI = 3'd6;
    localparam logic [OPCODE_W-1:0] OP_HLT = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } fetch_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [RETIRED_W-1:0] sat_inc(input logic [RETIRED_W-1:0] v);
        return (v == {RETIRED_W{1'b1}}) ? v : v + {{(RETIRED_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding the CPU controller.
//
// Holds the program counter and instruction register, reads one 16-bit word
// per instruction from instruction memory, presents opcode/operand to the
// controller for exactly one EXEC cycle, then applies the controller's
// pc_src / halt decision and counts retired instructions.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           leave IDLE/HALTED and begin fetching at RESET_PC
//   pc_src, halt    controller decisions, only looked at during EXEC
//   imem_req/addr   memory read request and address (address = pc)
//   imem_ack/rdata  memory response, only accepted during FETCH
//   instr_valid     opcode/operand valid this cycle (EXEC)
//   opcode, operand fields of the instruction register
//   pc              current program counter
//   halted          high while in HALTED
//   retired         saturating count of EXEC cycles since reset/restart
//
// Memory handshake: imem_req is raised in FETCH and held, together with an
// unchanging imem_addr, until imem_ack is seen. The word on imem_rdata is
// transferred in the cycle where imem_req and imem_ack are both high; an ack
// in any other cycle carries no data and is ignored. The memory may take any
// number of cycles to respond.
module fetch_unit #(
    parameter int ADDR_W  = cpu_pkg::ADDR_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pc_src,
    input  logic               halt,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [2:0]         opcode,
    output logic [ADDR_W-1:0]  operand,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted,
    output logic [15:0]        retired
);

    import cpu_pkg::*;

    localparam logic [ADDR_W-1:0] PC_ONE = 1;

    fetch_state_e        state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [15:0]         retired_q, retired_d;
    logic [2:0]          ir_opcode;
    logic [ADDR_W-1:0]   ir_operand;

    assign ir_opcode  = ir_q[INSTR_W-1 -: 3];
    assign ir_operand = ir_q[ADDR_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        retired_d   = retired_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pc_d      = RESET_PC;
                    retired_d = '0;
                    state_d   = FETCH;
                end
            end

            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = EXEC;
                end
            end

            EXEC: begin
                instr_valid = 1'b1;
                retired_d   = sat_inc(retired_q);
                // Halt takes priority over a jump; pc keeps pointing at the
                // instruction that stopped the machine.
                if (halt || ir_opcode == OP_HLT) begin
                    state_d = HALTED;
                end else begin
                    pc_d    = pc_src ? ir_operand : pc_q + PC_ONE;
                    state_d = FETCH;
                end
            end

            HALTED: begin
                halted = 1'b1;
                if (start) begin
                    pc_d      = RESET_PC;
                    retired_d = '0;
                    state_d   = FETCH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Driven from registers only, so reset silences imem_req immediately.
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign opcode    = ir_opcode;
    assign operand   = ir_operand;
    assign retired   = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        pc_src = 1'b0;
    logic        halt = 1'b0;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0;
    logic        imem_req;
    logic [12:0] imem_addr;
    logic        instr_valid;
    logic [2:0]  opcode;
    logic [12:0] operand;
    logic [12:0] pc;
    logic        halted;
    logic [15:0] retired;

    fetch_unit u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pc_src     (pc_src),
        .halt       (halt),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .opcode     (opcode),
        .operand    (operand),
        .pc         (pc),
        .halted     (halted),
        .retired    (retired)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- shared state ----------------
    logic [15:0] mem [0:8191];
    int          ack_wait;
    bit          junk_en;
    int          wait_cnt;
    bit          fetch_acked;
    int          n_tests;
    int          n_fail;

    typedef struct {
        logic [15:0] word;
        logic        src;
        logic        hlt;
        logic        exp_halted;
        logic [12:0] exp_pc;
    } vec_t;

    vec_t vecs [8];

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory responder plus one clock: called at a negedge, drives the memory
    // inputs for the coming posedge and returns at the following negedge.
    task automatic tick();
        fetch_acked = 1'b0;
        if (imem_req === 1'b1) begin
            if (wait_cnt >= ack_wait) begin
                imem_ack    = 1'b1;
                imem_rdata  = mem[imem_addr];
                wait_cnt    = 0;
                fetch_acked = 1'b1;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = junk_en ? 16'($urandom) : 16'h0;
                wait_cnt++;
            end
        end else begin
            wait_cnt   = 0;
            imem_ack   = junk_en ? 1'($urandom_range(0, 1)) : 1'b0;
            imem_rdata = 16'($urandom);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        for (int k = 0; k < 60 && instr_valid !== 1'b1; k++) tick();
        check(name, {31'h0, instr_valid}, 32'h1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        start    = 1'b0;
        pc_src   = 1'b0;
        halt     = 1'b0;
        imem_ack = 1'b0;
        wait_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
    endtask

    // ---------------- main test ----------------
    initial begin
        n_tests = 0;
        n_fail  = 0;
        junk_en = 1'b0;
        ack_wait = 0;
        wait_cnt = 0;

        vecs[0] = '{16'h0005, 1'b0, 1'b0, 1'b0, 13'h0001};
        vecs[1] = '{16'h8005, 1'b1, 1'b0, 1'b0, 13'h0005};
        vecs[2] = '{16'h8005, 1'b0, 1'b0, 1'b0, 13'h0001};
        vecs[3] = '{16'hA123, 1'b1, 1'b1, 1'b1, 13'h0000};
        vecs[4] = '{16'hE00A, 1'b1, 1'b0, 1'b1, 13'h0000};
        vecs[5] = '{16'h5ABC, 1'b1, 1'b0, 1'b0, 13'h1ABC};
        vecs[6] = '{16'h2000, 1'b0, 1'b1, 1'b1, 13'h0000};
        vecs[7] = '{16'hC7FF, 1'b1, 1'b0, 1'b0, 13'h07FF};

        // ---- 1: three instructions with same-cycle ack, ending in HLT ----
        clear_mem();
        mem[0] = 16'h0000;
        mem[1] = 16'h4001;
        mem[2] = 16'hE000;
        do_reset();
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_halted", {31'h0, halted}, 32'h0);
        check("rst_pc", {19'h0, pc}, 32'h0);
        check("rst_retired", {16'h0, retired}, 32'h0);
        check("rst_ir", {16'h0, opcode, operand}, 32'h0);
        begin
            logic [2:0] exp_op [3];
            int nv;
            exp_op[0] = 3'd0; exp_op[1] = 3'd2; exp_op[2] = 3'd7;
            nv = 0;
            pulse_start();
            for (int k = 1; k <= 8; k++) begin
                if (k > 1) tick();
                check("t1_valid", {31'h0, instr_valid},
                      {31'h0, (k == 2 || k == 4 || k == 6)});
                if (instr_valid === 1'b1 && nv < 3) begin
                    check("t1_pc", {19'h0, pc}, nv);
                    check("t1_opcode", {29'h0, opcode}, {29'h0, exp_op[nv]});
                    nv++;
                end
            end
        end
        check("t1_halted", {31'h0, halted}, 32'h1);
        check("t1_retired", {16'h0, retired}, 32'd3);
        junk_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t1_req_quiet", {31'h0, imem_req}, 32'h0);
            check("t1_valid_quiet", {31'h0, instr_valid}, 32'h0);
        end
        junk_en = 1'b0;

        // ---- 2: every fetch waits, request held for 5 cycles ----
        clear_mem();
        mem[2] = 16'hE000;
        ack_wait = 4;
        do_reset();
        pulse_start();
        begin
            int run;
            int nv;
            logic [12:0] addr0;
            run = 0;
            nv = 0;
            addr0 = '0;
            for (int k = 0; k < 60 && halted !== 1'b1; k++) begin
                if (imem_req === 1'b1) begin
                    if (run == 0) begin
                        addr0 = imem_addr;
                        check("t2_addr", {19'h0, imem_addr}, nv);
                    end else begin
                        check("t2_addr_stable", {19'h0, imem_addr}, {19'h0, addr0});
                    end
                    run++;
                end
                if (instr_valid === 1'b1) begin
                    check("t2_req_len", run, 5);
                    run = 0;
                    nv++;
                end
                tick();
            end
            check("t2_valid_count", nv, 3);
            check("t2_halted", {31'h0, halted}, 32'h1);
        end
        ack_wait = 0;

        // ---- table: one EXEC decision from pc=0 ----
        for (int v = 0; v < 8; v++) begin
            clear_mem();
            mem[0] = vecs[v].word;
            do_reset();
            pulse_start();
            wait_valid("tab_wait");
            check("tab_opcode", {29'h0, opcode}, {29'h0, vecs[v].word[15:13]});
            check("tab_operand", {19'h0, operand}, {19'h0, vecs[v].word[12:0]});
            pc_src = vecs[v].src;
            halt   = vecs[v].hlt;
            tick();
            pc_src = 1'b0;
            halt   = 1'b0;
            check("tab_halted", {31'h0, halted}, {31'h0, vecs[v].exp_halted});
            check("tab_pc", {19'h0, pc}, {19'h0, vecs[v].exp_pc});
            check("tab_req", {31'h0, imem_req}, {31'h0, !vecs[v].exp_halted});
            check("tab_retired", {16'h0, retired}, 32'd1);
        end

        // ---- 3: JMP word at pc=3, taken and not taken ----
        for (int s = 1; s >= 0; s--) begin
            clear_mem();
            mem[0] = 16'h8003;
            mem[3] = 16'h8005;
            do_reset();
            pulse_start();
            wait_valid("t3_wait0");
            pc_src = 1'b1;
            tick();
            pc_src = 1'b0;
            check("t3_addr3", {19'h0, imem_addr}, 32'd3);
            wait_valid("t3_wait1");
            check("t3_pc", {19'h0, pc}, 32'd3);
            pc_src = s[0];
            tick();
            pc_src = 1'b0;
            check("t3_next_addr", {19'h0, imem_addr}, (s == 1) ? 32'd5 : 32'd4);
        end

        // ---- 4: pc wraps from 8191 to 0 ----
        clear_mem();
        mem[0] = 16'h9FFF;
        mem[8191] = 16'h0000;
        do_reset();
        pulse_start();
        wait_valid("t4_wait0");
        pc_src = 1'b1;
        tick();
        pc_src = 1'b0;
        check("t4_addr_top", {19'h0, imem_addr}, 32'h1FFF);
        wait_valid("t4_wait1");
        tick();
        check("t4_wrap", {19'h0, imem_addr}, 32'h0);
        check("t4_req", {31'h0, imem_req}, 32'h1);

        // ---- 5: halt with pc_src, then restart ----
        clear_mem();
        mem[1] = 16'h8007;
        do_reset();
        pulse_start();
        wait_valid("t5_wait0");
        tick();
        wait_valid("t5_wait1");
        check("t5_pc1", {19'h0, pc}, 32'd1);
        pc_src = 1'b1;
        halt   = 1'b1;
        tick();
        pc_src = 1'b0;
        halt   = 1'b0;
        check("t5_halted", {31'h0, halted}, 32'h1);
        check("t5_pc_kept", {19'h0, pc}, 32'd1);
        check("t5_retired", {16'h0, retired}, 32'd2);
        pulse_start();
        check("t5_restart_addr", {19'h0, imem_addr}, 32'd0);
        check("t5_restart_ret", {16'h0, retired}, 32'd0);
        check("t5_restart_req", {31'h0, imem_req}, 32'h1);
        check("t5_restart_halt", {31'h0, halted}, 32'h0);

        // ---- 6: asynchronous reset while a fetch is pending ----
        clear_mem();
        mem[0] = 16'hE000;
        ack_wait = 1000;
        do_reset();
        pulse_start();
        tick();
        tick();
        check("t6_req_pending", {31'h0, imem_req}, 32'h1);
        #2 rst = 1'b1;
        #1 check("t6_req_drop", {31'h0, imem_req}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            imem_ack   = 1'b1;
            imem_rdata = 16'h8ABC;
            @(posedge clk);
            @(negedge clk);
            check("t6_idle_req", {31'h0, imem_req}, 32'h0);
            check("t6_idle_valid", {31'h0, instr_valid}, 32'h0);
        end
        imem_ack = 1'b0;
        ack_wait = 0;
        wait_cnt = 0;
        pulse_start();
        check("t6_start_req", {31'h0, imem_req}, 32'h1);
        wait_valid("t6_wait");
        check("t6_opcode", {29'h0, opcode}, 32'd7);

        // ---- random: instruction-level reference model ----
        for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
        junk_en = 1'b1;
        ack_wait = $urandom_range(0, 3);
        do_reset();
        begin
            bit          m_active;
            bit          m_halted;
            bit          was_active;
            bit          exp_valid;
            logic [12:0] m_pc;
            int          m_retired;
            logic [15:0] word;
            m_active  = 1'b0;
            m_halted  = 1'b0;
            m_pc      = 13'h0;
            m_retired = 0;
            exp_valid = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                check("rnd_valid", {31'h0, instr_valid}, {31'h0, exp_valid});
                check("rnd_halted", {31'h0, halted}, {31'h0, m_halted});
                check("rnd_req", {31'h0, imem_req}, {31'h0, m_active && !exp_valid});
                check("rnd_retired", {16'h0, retired}, m_retired);
                if (imem_req === 1'b1)
                    check("rnd_addr", {19'h0, imem_addr}, {19'h0, m_pc});
                if (instr_valid === 1'b1) begin
                    check("rnd_pc", {19'h0, pc}, {19'h0, m_pc});
                    check("rnd_opcode", {29'h0, opcode}, {29'h0, mem[m_pc][15:13]});
                    check("rnd_operand", {19'h0, operand}, {19'h0, mem[m_pc][12:0]});
                end

                pc_src = 1'($urandom_range(0, 1));
                halt   = ($urandom_range(0, 7) == 0);
                start  = ($urandom_range(0, 3) == 0);

                was_active = m_active;
                if (exp_valid) begin
                    word = mem[m_pc];
                    if (m_retired < 65535) m_retired++;
                    if (halt || word[15:13] == 3'd7) begin
                        m_active = 1'b0;
                        m_halted = 1'b1;
                    end else if (pc_src) begin
                        m_pc = word[12:0];
                    end else begin
                        m_pc = m_pc + 13'd1;
                    end
                end
                if (!was_active && start) begin
                    m_active  = 1'b1;
                    m_halted  = 1'b0;
                    m_pc      = 13'h0;
                    m_retired = 0;
                end

                tick();
                exp_valid = fetch_acked;
                if (fetch_acked) ack_wait = $urandom_range(0, 3);
            end
        end
        start  = 1'b0;
        pc_src = 1'b0;
        halt   = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the CPU controller.
- Holds the program counter and instruction register.
- Fetches 16-bit instructions from instruction memory over a req/ack handshake.
- Presents opcode and operand to the controller for exactly one cycle per instruction.
- Applies the controller's pc_src and halt decisions and counts retired instructions.

Parameters:
ADDR_W, 13, PC / instruction address width (operand field width).
INSTR_W, 16, instruction width; opcode = instr[15:13], operand = instr[12:0].
RESET_PC, 0, PC value loaded on reset and on restart.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  asynchronous reset, active-high.
start  input  1  leave IDLE/HALTED and begin fetching at RESET_PC.
pc_src  input  1  from controller: take jump to operand (sampled in EXEC only).
halt  input  1  from controller: stop after current instruction (sampled in EXEC only).
imem_req  output  1  instruction memory read request.
imem_addr  output  ADDR_W  instruction memory address (= pc).
imem_ack  input  1  memory returns imem_rdata this cycle.
imem_rdata  input  INSTR_W  instruction word.
instr_valid  output  1  opcode/operand valid; controller outputs are consumed this cycle.
opcode  output  3  ir[15:13].
operand  output  ADDR_W  ir[12:0] (memory address or immediate).
pc  output  ADDR_W  current program counter.
halted  output  1  high in HALTED state.
retired  output  16  count of EXEC cycles since reset or restart, saturating.

Behaviour:
Reset (async, immediate) forces the following; imem_req drops combinationally-fast.
- state=IDLE, pc=RESET_PC, ir=0, retired=0.
- imem_req=0, instr_valid=0, halted=0.

FSM states IDLE, FETCH, EXEC, HALTED:
- IDLE: outputs quiet. start=1 -> FETCH next cycle, with pc=RESET_PC and retired=0.
- FETCH: imem_req=1, imem_addr=pc.
  - imem_addr stays stable while req is high.
  - On imem_ack=1: ir<=imem_rdata, go to EXEC.
  - With no ack, stay; any wait length is allowed.
- EXEC: exactly one cycle, instr_valid=1, imem_req=0.
  - retired increments, saturating at 16'hFFFF.
  - If halt=1 or opcode==3'b111: go to HALTED, pc unchanged.
  - Else if pc_src=1: pc<=operand, go to FETCH.
  - Else: pc<=pc+1, go to FETCH.
  - pc+1 wraps modulo 2^ADDR_W (8191 -> 0).
- HALTED: halted=1, no requests. start=1 -> pc<=RESET_PC, retired<=0, go to FETCH.

Latency: minimum 2 cycles per instruction (FETCH with same-cycle ack, then EXEC).

Boundary and simultaneous-event rules:
- imem_ack outside FETCH is ignored.
- start outside IDLE/HALTED is ignored.
- pc_src and halt outside EXEC are ignored.
- halt and pc_src both high in EXEC: halt wins; pc is not updated.
- opcode, operand and ir hold their last values outside EXEC; only instr_valid qualifies them.
- Reset mid-FETCH abandons the request. A late ack after reset is ignored because state=IDLE.
- The datapath must not act on controller outputs unless instr_valid=1.

Decomposition:
Shared package cpu_pkg holds:
- widths ADDR_W and INSTR_W;
- opcode constants OP_LDA=0, OP_STA=1, OP_ADD=2, OP_SUB=3, OP_JMP=4, OP_JEZ=5, OP_LDI=6, OP_HLT=7;
- the fetch state enum (IDLE, FETCH, EXEC, HALTED).

No sub-module is natural; a single module with the FSM, PC/IR registers and saturating counter.

Test Plan:
1. Reset then start with ack in the same cycle; memory holds 0x0000, 0x4001, 0xE000.
   - instr_valid pulses at cycles 2, 4, 6 after start.
   - pc goes 0 -> 1 -> 2; opcode 7 enters HALTED.
   - retired=3; halted=1; imem_req stays 0 thereafter.
2. Ack delayed 5 cycles on every fetch -> imem_req held high and imem_addr stable for 5 cycles; one instr_valid per ack.
3. Word 0x8005 at pc=3 with pc_src=1 in EXEC -> next imem_addr=5. With pc_src=0 -> next imem_addr=4.
4. pc=13'h1FFF with no jump -> next imem_addr=0.
5. halt=1 together with pc_src=1 in EXEC -> HALTED with pc unchanged. Then start -> imem_addr=RESET_PC and retired=0.
6. Assert rst asynchronously while imem_req=1 and waiting -> imem_req=0 before the next edge. A later ack is ignored, and the FSM stays IDLE until start.
